// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared datapath
// with a mem_ready handshake, trapping on illegal opcodes and memory timeouts.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        ZeroFlag,
    input  logic        NegativeFlag,
    input  logic        OverflowFlag,
    input  logic        CarryFlag,
    output logic        mem_req,
    output logic        MemWrite,
    output logic [1:0]  MemSize,
    output logic        ExtSign,
    output logic        ir_write,
    output logic        pc_write,
    output logic        PCSel,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  AluSrcASel,
    output logic [1:0]  AluSrcBSel,
    output logic [3:0]  AluOp,
    output logic [2:0]  ImmSel,
    output logic        trap,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP    = 3'd5
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
    localparam logic [1:0] RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC = 2'd2;

    // Counter only has to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, legal, is_load, is_store, taken;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign state    = state_q;

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = ZeroFlag;
            3'b001:  taken = !ZeroFlag;
            3'b100:  taken = NegativeFlag ^ OverflowFlag;
            3'b101:  taken = !(NegativeFlag ^ OverflowFlag);
            3'b110:  taken = !CarryFlag;
            3'b111:  taken = CarryFlag;
            default: taken = 1'b0;
        endcase
    end

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30,
                                              input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return b30 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else                    state_d = is_load ? S_WB : S_FETCH;
                end else if ((MEM_TIMEOUT > 0) && (wait_q == WAIT_LIMIT)) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal)             state_d = S_EXECUTE;
                else if (ILLEGAL_TRAP) state_d = S_TRAP;
                else                   state_d = S_FETCH;
            end
            S_EXECUTE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE:                    state_d = S_MEM;
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: state_d = S_WB;
                    default:                                state_d = S_FETCH;
                endcase
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        MemSize    = 2'd0;
        ExtSign    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        PCSel      = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALU;
        AluSrcASel = A_RS1;
        AluSrcBSel = B_RS2;
        AluOp      = ALU_ADD;
        ImmSel     = IMM_I;
        trap       = 1'b0;
        // Gated by rst so mem_req drops the instant reset is asserted.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    MemSize    = 2'd2;
                    AluSrcASel = A_PC;
                    AluSrcBSel = B_FOUR;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    AluSrcASel = A_PC;
                    AluSrcBSel = B_IMM;
                    case (opcode)
                        OPC_STORE:          ImmSel = IMM_S;
                        OPC_BRANCH:         ImmSel = IMM_B;
                        OPC_LUI, OPC_AUIPC: ImmSel = IMM_U;
                        OPC_JAL:            ImmSel = IMM_J;
                        default:            ImmSel = IMM_I;
                    endcase
                end
                S_EXECUTE: begin
                    case (opcode)
                        OPC_OP:    AluOp = alu_decode(funct3, funct7b5, 1'b1);
                        OPC_OPIMM: begin
                            AluSrcBSel = B_IMM;
                            AluOp      = alu_decode(funct3, funct7b5, 1'b0);
                        end
                        OPC_LUI, OPC_AUIPC: begin
                            AluSrcASel = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                            AluSrcBSel = B_IMM;
                            ImmSel     = IMM_U;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            AluSrcBSel = B_IMM;
                            ImmSel     = is_store ? IMM_S : IMM_I;
                        end
                        OPC_BRANCH: begin
                            AluOp    = ALU_SUB;
                            pc_write = taken;
                            PCSel    = taken;
                        end
                        OPC_JAL, OPC_JALR: begin
                            AluSrcBSel = (opcode == OPC_JALR) ? B_IMM : B_RS2;
                            pc_write   = 1'b1;
                            PCSel      = (opcode == OPC_JAL);
                            RegWrite   = 1'b1;
                            ResultSrc  = RES_PC;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    MemWrite = is_store;
                    MemSize  = funct3[1:0];
                    ExtSign  = is_load && !funct3[2];
                end
                S_WB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = is_load ? RES_MEM : RES_ALU;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus random instruction streams
// compared cycle by cycle against a sequence model built from the instruction rules.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       mw;
        logic [1:0] msz;
        logic       ext;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       rw;
        logic [1:0] rsrc;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [3:0] aop;
        logic [2:0] isel;
        logic       trp;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        int         b30;   // -1: free immediate bit
        logic [3:0] aop;
    } alu_ent_t;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                           XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;
    localparam logic [2:0] IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2, IM_U = 3'd3, IM_J = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] instr = '0;
    logic mem_ready = 1'b0;
    logic ZeroFlag = 1'b0, NegativeFlag = 1'b0, OverflowFlag = 1'b0, CarryFlag = 1'b0;
    logic [31:0] stage_instr = '0;
    logic [3:0]  stage_flags = '0;   // {Z, N, V, C}
    int errors = 0;
    int checks = 0;
    alu_ent_t alu_tab [19];

    always #5 clk = ~clk;

    logic       req_a, mw_a, ext_a, irw_a, pcw_a, pcs_a, rw_a, trp_a;
    logic [1:0] msz_a, rsrc_a, asel_a, bsel_a;
    logic [3:0] aop_a;
    logic [2:0] isel_a, st_a;
    logic       req_b, mw_b, ext_b, irw_b, pcw_b, pcs_b, rw_b, trp_b;
    logic [1:0] msz_b, rsrc_b, asel_b, bsel_b;
    logic [3:0] aop_b;
    logic [2:0] isel_b, st_b;
    out_t obs_a, obs_b;

    assign obs_a = {st_a, req_a, mw_a, msz_a, ext_a, irw_a, pcw_a, pcs_a, rw_a, rsrc_a, asel_a, bsel_a, aop_a, isel_a, trp_a};
    assign obs_b = {st_b, req_b, mw_b, msz_b, ext_b, irw_b, pcw_b, pcs_b, rw_b, rsrc_b, asel_b, bsel_b, aop_b, isel_b, trp_b};

    multicycle_control_unit #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .ZeroFlag(ZeroFlag), .NegativeFlag(NegativeFlag), .OverflowFlag(OverflowFlag), .CarryFlag(CarryFlag),
        .mem_req(req_a), .MemWrite(mw_a), .MemSize(msz_a), .ExtSign(ext_a), .ir_write(irw_a),
        .pc_write(pcw_a), .PCSel(pcs_a), .RegWrite(rw_a), .ResultSrc(rsrc_a), .AluSrcASel(asel_a),
        .AluSrcBSel(bsel_a), .AluOp(aop_a), .ImmSel(isel_a), .trap(trp_a), .state(st_a)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4), .ILLEGAL_TRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .ZeroFlag(ZeroFlag), .NegativeFlag(NegativeFlag), .OverflowFlag(OverflowFlag), .CarryFlag(CarryFlag),
        .mem_req(req_b), .MemWrite(mw_b), .MemSize(msz_b), .ExtSign(ext_b), .ir_write(irw_b),
        .pc_write(pcw_b), .PCSel(pcs_b), .RegWrite(rw_b), .ResultSrc(rsrc_b), .AluSrcASel(asel_b),
        .AluSrcBSel(bsel_b), .AluOp(aop_b), .ImmSel(isel_b), .trap(trp_b), .state(st_b)
    );

    task automatic check(input string tag, input out_t obs, input out_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare both units shortly after.
    task automatic step(input out_t e, input logic rdy, input string tag);
        @(negedge clk);
        instr = stage_instr;
        {ZeroFlag, NegativeFlag, OverflowFlag, CarryFlag} = stage_flags;
        mem_ready = rdy;
        #1;
        check({tag, "/a"}, obs_a, e);
        check({tag, "/b"}, obs_b, e);
    endtask

    function automatic out_t blank(input logic [2:0] st);
        out_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic out_t fetch_exp(input logic rdy);
        out_t e = blank(ST_F);
        e.req = 1'b1; e.msz = 2'd2; e.asel = 2'd1; e.bsel = 2'd2; e.aop = ADD;
        e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    function automatic out_t trap_exp();
        out_t e = blank(ST_T);
        e.trp = 1'b1;
        return e;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check({tag, "/a"}, obs_a, '0);
        check({tag, "/b"}, obs_b, '0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Model of one instruction's cycle sequence: wf/wm are wait cycles before mem_ready in FETCH/MEM.
    // abort=1 returns after the first MEM wait cycle; illegal opcodes return after DECODE.
    task automatic run_instr(input logic [31:0] iw, input logic [3:0] aop, input logic [3:0] fl,
                             input int wf, input int wm, input int abort, input string tag);
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, n, v, c, taken, is_ld, is_st, to_wb;
        out_t       e;
        op = iw[6:0];
        f3 = iw[14:12];
        {z, n, v, c} = fl;
        is_ld = (op == 7'h03);
        is_st = (op == 7'h23);
        stage_instr = iw;
        stage_flags = fl;
        for (int i = 0; i <= wf; i++)
            step(fetch_exp(i == wf), i == wf, $sformatf("%s/fetch%0d", tag, i));
        e = blank(ST_D); e.asel = 2'd1; e.bsel = 2'd1;
        case (op)
            7'h23:          e.isel = IM_S;
            7'h63:          e.isel = IM_B;
            7'h37, 7'h17:   e.isel = IM_U;
            7'h6F:          e.isel = IM_J;
            default:        e.isel = IM_I;
        endcase
        step(e, 1'($urandom_range(0, 1)), {tag, "/decode"});
        if (!(op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F})) return;
        e = blank(ST_E);
        to_wb = 1'b0;
        case (op)
            7'h33: begin e.aop = aop; to_wb = 1'b1; end
            7'h13: begin e.bsel = 2'd1; e.aop = aop; to_wb = 1'b1; end
            7'h37: begin e.asel = 2'd2; e.bsel = 2'd1; e.isel = IM_U; to_wb = 1'b1; end
            7'h17: begin e.asel = 2'd1; e.bsel = 2'd1; e.isel = IM_U; to_wb = 1'b1; end
            7'h03: begin e.bsel = 2'd1; end
            7'h23: begin e.bsel = 2'd1; e.isel = IM_S; end
            7'h63: begin
                case (f3)
                    3'd0: taken = z;
                    3'd1: taken = !z;
                    3'd4: taken = n ^ v;
                    3'd5: taken = !(n ^ v);
                    3'd6: taken = !c;
                    default: taken = c;
                endcase
                e.aop = SUB; e.pcw = taken; e.pcs = taken;
            end
            7'h6F: begin e.pcw = 1'b1; e.pcs = 1'b1; e.rw = 1'b1; e.rsrc = 2'd2; end
            default: begin e.bsel = 2'd1; e.pcw = 1'b1; e.rw = 1'b1; e.rsrc = 2'd2; end
        endcase
        step(e, 1'($urandom_range(0, 1)), {tag, "/exec"});
        if (is_ld || is_st) begin
            for (int i = 0; i <= wm; i++) begin
                e = blank(ST_M); e.req = 1'b1; e.mw = is_st;
                case (f3)
                    3'd0: begin e.msz = 2'd0; e.ext = is_ld; end
                    3'd1: begin e.msz = 2'd1; e.ext = is_ld; end
                    3'd2: begin e.msz = 2'd2; e.ext = is_ld; end
                    3'd4: begin e.msz = 2'd0; e.ext = 1'b0; end
                    default: begin e.msz = 2'd1; e.ext = 1'b0; end
                endcase
                step(e, i == wm, $sformatf("%s/mem%0d", tag, i));
                if (abort != 0) return;
            end
            to_wb = is_ld;
        end
        if (to_wb) begin
            e = blank(ST_W); e.rw = 1'b1; e.rsrc = is_ld ? 2'd1 : 2'd0;
            step(e, 1'($urandom_range(0, 1)), {tag, "/wb"});
        end
    endtask

    initial begin
        logic [31:0] iw;
        logic [3:0]  aop;
        int          k, idx;
        out_t        e;
        alu_tab = '{
            '{7'h33, 3'd0, 0, ADD},  '{7'h33, 3'd0, 1, SUB},  '{7'h33, 3'd1, 0, SLL},
            '{7'h33, 3'd2, 0, SLT},  '{7'h33, 3'd3, 0, SLTU}, '{7'h33, 3'd4, 0, XOR},
            '{7'h33, 3'd5, 0, SRL},  '{7'h33, 3'd5, 1, SRA},  '{7'h33, 3'd6, 0, OR},
            '{7'h33, 3'd7, 0, AND},  '{7'h13, 3'd0, -1, ADD}, '{7'h13, 3'd2, -1, SLT},
            '{7'h13, 3'd3, -1, SLTU}, '{7'h13, 3'd4, -1, XOR}, '{7'h13, 3'd6, -1, OR},
            '{7'h13, 3'd7, -1, AND}, '{7'h13, 3'd1, 0, SLL},  '{7'h13, 3'd5, 0, SRL},
            '{7'h13, 3'd5, 1, SRA}
        };

        do_reset("reset");
        run_instr(32'h002081B3, ADD, 4'h0, 0, 0, 0, "add");
        run_instr(32'h40208233, SUB, 4'h0, 1, 0, 0, "sub");
        run_instr(32'h00208063, ADD, 4'h8, 0, 0, 0, "beq_taken");
        run_instr(32'h00208063, ADD, 4'h0, 0, 0, 0, "beq_not_taken");
        run_instr(32'h0000D283, ADD, 4'h0, 0, 3, 0, "lhu_wait3");
        run_instr(32'h0020A023, ADD, 4'h0, 0, 1, 0, "sw");
        run_instr(32'h008000EF, ADD, 4'h0, 0, 0, 0, "jal");
        run_instr(32'h000080E7, ADD, 4'h0, 2, 0, 0, "jalr");
        run_instr(32'h123452B7, ADD, 4'h0, 0, 0, 0, "lui");
        run_instr(32'h00001297, ADD, 4'h0, 0, 0, 0, "auipc");

        for (int n = 0; n < 200; n++) begin
            iw = $urandom;
            aop = ADD;
            k = $urandom_range(0, 8);
            case (k)
                0, 8: begin
                    idx = $urandom_range(0, 18);
                    iw[6:0] = alu_tab[idx].op;
                    iw[14:12] = alu_tab[idx].f3;
                    if (alu_tab[idx].b30 >= 0) iw[31:25] = (alu_tab[idx].b30 == 1) ? 7'h20 : 7'h00;
                    aop = alu_tab[idx].aop;
                end
                1: iw[6:0] = 7'h37;
                2: iw[6:0] = 7'h17;
                3: begin
                    iw[6:0] = 7'h03;
                    case ($urandom_range(0, 4))
                        0: iw[14:12] = 3'd0;
                        1: iw[14:12] = 3'd1;
                        2: iw[14:12] = 3'd2;
                        3: iw[14:12] = 3'd4;
                        default: iw[14:12] = 3'd5;
                    endcase
                end
                4: begin iw[6:0] = 7'h23; iw[14:12] = 3'($urandom_range(0, 2)); end
                5: begin
                    iw[6:0] = 7'h63;
                    iw[14:12] = 3'($urandom_range(0, 5));
                    if (iw[14:12] >= 3'd2) iw[14:12] = iw[14:12] + 3'd2;
                end
                6: iw[6:0] = 7'h6F;
                default: begin iw[6:0] = 7'h67; iw[14:12] = 3'd0; end
            endcase
            run_instr(iw, aop, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0,
                      $sformatf("rnd%0d", n));
        end

        // Illegal opcode: trapping unit halts, non-trapping unit refetches.
        run_instr(32'h0000007F, ADD, 4'h0, 0, 0, 0, "illegal");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("illegal/trap_a", obs_a, trap_exp());
        check("illegal/fetch_b", obs_b, fetch_exp(1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            check($sformatf("illegal/hold%0d", i), obs_a, trap_exp());
        end
        do_reset("reset_after_illegal");

        // Reset pulsed while a load waits in MEM.
        run_instr(32'h0000A283, ADD, 4'h0, 0, 2, 1, "lw_abort");
        #2 rst = 1'b1;
        #1;
        check("midrst/a", obs_a, '0);
        check("midrst/b", obs_b, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(32'h002081B3, ADD, 4'h0, 0, 0, 0, "add_after_rst");

        // Fetch timeout: four cycles without mem_ready, then TRAP held until reset.
        for (int i = 0; i < 4; i++) step(fetch_exp(1'b0), 1'b0, $sformatf("tmo/wait%0d", i));
        for (int i = 0; i < 3; i++) step(trap_exp(), 1'b1, $sformatf("tmo/trap%0d", i));
        do_reset("reset_after_timeout");
        run_instr(32'h0000C283, ADD, 4'h0, 3, 0, 0, "lbu_after_tmo");

        e = fetch_exp(1'b0);
        step(e, 1'b0, "final_fetch");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RV32I core. It is the successor to the single-cycle combinational decoder and sequences every instruction through FETCH/DECODE/EXECUTE/MEM/WB over a shared datapath and a latency-tolerant memory handshake. It adds stores, branches, JAL/JALR, LUI and AUIPC, plus illegal-opcode and memory-timeout trapping. ALU op, immediate-select and opcode encodings come from the core's shared defines.

## Interface
- MEM_TIMEOUT, 16: max wait cycles for mem_ready; 0 disables the timeout.
- ILLEGAL_TRAP, 1: 1 means an unknown opcode enters TRAP; 0 means it retires as a NOP.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- instr  in  32  instruction register contents (opcode, funct3, funct7 fields).
- mem_ready  in  1  memory has completed the current request.
- ZeroFlag, NegativeFlag, OverflowFlag, CarryFlag  in  1 each  combinational ALU flags.
- mem_req  out  1  memory request; held until mem_ready.
- MemWrite  out  1  request is a store.
- MemSize  out  2  0 = byte, 1 = half, 2 = word.
- ExtSign  out  1  sign-extend load data.
- ir_write  out  1  latch instr and old_pc.
- pc_write  out  1  update PC.
- PCSel  out  1  0 = ALU result, 1 = alu_out register.
- RegWrite  out  1  write rd.
- ResultSrc  out  2  0 = alu_out, 1 = memory data, 2 = PC.
- AluSrcASel  out  2  0 = rs1, 1 = old_pc, 2 = zero.
- AluSrcBSel  out  2  0 = rs2, 1 = immediate, 2 = constant 4.
- AluOp  out  4  ALU operation.
- ImmSel  out  3  immediate format.
- trap  out  1  core halted.
- state  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.

## Operation
- FETCH: mem_req=1, MemSize=word, A=old_pc-path PC, B=4, AluOp=ADD.
  - On mem_ready: ir_write=1, pc_write=1, PCSel=0; go to DECODE.
- DECODE: A=old_pc, B=imm, AluOp=ADD, ImmSel from opcode; the datapath latches this into alu_out as the branch/JAL target.
  - Illegal opcode: TRAP if ILLEGAL_TRAP=1, else back to FETCH.
- EXECUTE:
  - R/I-ALU: AluOp decoded as in the single-cycle unit (funct7[5] selects SUB/SRA); go to WB.
  - LUI: A=zero, B=U-imm; go to WB.
  - AUIPC: A=old_pc, B=U-imm; go to WB.
  - Load/store: A=rs1, B=imm, ADD; go to MEM.
  - Branch: A=rs1, B=rs2, SUB. Taken flag per funct3:
    - BEQ: Z. BNE: !Z.
    - BLT: N^V. BGE: !(N^V).
    - BLTU: !C. BGEU: C.
    - If taken: pc_write=1, PCSel=1. Go to FETCH.
  - JAL: pc_write=1, PCSel=1, RegWrite=1, ResultSrc=2; go to FETCH.
  - JALR: A=rs1, B=I-imm, ADD, pc_write=1, PCSel=0 (datapath clears bit 0), RegWrite=1, ResultSrc=2; go to FETCH.
- MEM: mem_req=1; MemWrite=1 for stores; MemSize/ExtSign from funct3 (lb/lh/lw/lbu/lhu; sb/sh/sw).
  - On mem_ready: a store goes to FETCH; a load goes to WB with ResultSrc=1.
- WB: RegWrite=1, ResultSrc=0, except ResultSrc=1 for loads; go to FETCH.
- TRAP: trap=1, every strobe 0; held until rst.
- Default when not driven: every strobe is 0.

## Timing
- Reset:
  - Asynchronous entry to FETCH; wait counter cleared.
  - While rst=1 every output is 0, including mem_req.
  - Fetch starts on the first rising edge after rst deasserts.
- Outputs are combinational from state, instr, flags and mem_ready. Transitions occur on the rising clk edge.
- Latency with mem_ready returned the same cycle:
  - ALU/LUI/AUIPC: 4 cycles. Load: 5. Store: 4.
  - Branch/JAL/JALR: 3.
  - Each wait cycle adds 1.
- Wait counter:
  - Counts cycles in FETCH or MEM with mem_ready=0; cleared on mem_ready or on a state change.
  - When MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with mem_ready still 0, the next state is TRAP.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- rst asserted mid-instruction: any pending mem_req drops immediately. A partial instruction has no architectural effect beyond writes already committed on earlier edges.
- mem_ready outside FETCH/MEM is ignored.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with mem_ready=1 -> state sequence 0,1,2,4,0; AluOp=ADD in EXECUTE; RegWrite only in WB.
- `beq` with Z=1, then with Z=0 -> pc_write=1 and PCSel=1 in EXECUTE only when Z=1; 3 cycles each.
- `lhu` with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with MemSize=1 and ExtSign=0; then WB with ResultSrc=1.
- `sw` -> MEM with MemWrite=1 and MemSize=2; returns to FETCH with no RegWrite.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> TRAP after 4 cycles; trap=1 until rst.
- Opcode 0x7F -> TRAP when ILLEGAL_TRAP=1; FETCH after DECODE when ILLEGAL_TRAP=0.
- rst pulsed during a MEM wait -> mem_req=0 immediately; FETCH after release.
